// File: rtl/sprite_port_arbiter_if.sv
// Port-A sharing bus between the SPI upload path, the renderer fetch and
// sprite storage. The slave modport is the arbiter's view.
interface sprite_port_arbiter_if #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              wq_valid;
  logic              wq_ready;
  logic [SEL_W-1:0]  wq_select;
  logic [ADDR_W-1:0] wq_addr;
  logic [7:0]        wq_data;

  logic              rd_req;
  logic [SEL_W-1:0]  rd_select;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_valid;

  logic              mem_we;
  logic [SEL_W-1:0]  mem_select;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  wq_valid, wq_select, wq_addr, wq_data,
    input  rd_req, rd_select, rd_addr,
    output wq_ready, rd_grant, rd_valid,
    output mem_we, mem_select, mem_addr, mem_wdata, fifo_level
  );

  modport master (
    output wq_valid, wq_select, wq_addr, wq_data,
    output rd_req, rd_select, rd_addr,
    input  wq_ready, rd_grant, rd_valid,
    input  mem_we, mem_select, mem_addr, mem_wdata, fifo_level
  );
endinterface

// File: rtl/sprite_port_arbiter.sv
// Sprite storage port-A arbiter: renderer reads win each slot, upload writes
// are buffered in a small FIFO, and a deferral counter forces one write slot
// after MAX_DEFER lost read slots so uploads cannot starve.
module sprite_port_arbiter #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_DEFER  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sprite_port_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned DEF_W = $clog2(MAX_DEFER + 1);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE,
    SLOT_FORCE
  } slot_e;

  entry_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [DEF_W-1:0]        defer_q, defer_d;
  logic                    rd_valid_q, rd_valid_d;

  slot_e  slot;
  entry_t head;
  logic   not_empty;
  logic   force_wr;
  logic   push;
  logic   pop;

  assign not_empty = (level_q != '0);
  assign force_wr  = not_empty && (defer_q == DEF_W'(MAX_DEFER));
  assign head      = fifo_q[rd_ptr_q];
  assign push      = bus.wq_valid && bus.wq_ready;
  assign pop       = (slot == SLOT_WRITE) || (slot == SLOT_FORCE);

  assign bus.wq_ready   = reset_n && (level_q < LVL_W'(FIFO_DEPTH));
  assign bus.rd_grant   = (slot == SLOT_READ);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.mem_we     = pop;
  assign bus.mem_select = pop ? head.sel  : bus.rd_select;
  assign bus.mem_addr   = pop ? head.addr : bus.rd_addr;
  assign bus.mem_wdata  = head.data;
  assign bus.fifo_level = level_q;

  // One slot decision per cycle; nothing is granted while reset is held.
  always_comb begin
    slot = SLOT_IDLE;
    if (!reset_n)       slot = SLOT_IDLE;
    else if (force_wr)  slot = SLOT_FORCE;
    else if (bus.rd_req) slot = SLOT_READ;
    else if (not_empty) slot = SLOT_WRITE;
  end

  // Next-state for FIFO storage, pointers, level, deferral count and read-valid.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    defer_d    = defer_q;
    rd_valid_d = bus.rd_grant;

    if (push) begin
      fifo_d[wr_ptr_q] = entry_t'{bus.wq_select, bus.wq_addr, bus.wq_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // The counter only measures how long the current head has been waiting,
    // so an empty FIFO or any write slot restarts it.
    if (!not_empty || pop) begin
      defer_d = '0;
    end else if ((slot == SLOT_READ) && (defer_q != DEF_W'(MAX_DEFER))) begin
      defer_d = defer_q + DEF_W'(1);
    end
  end

  // State registers; buffered data need no reset since the level gates it.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      defer_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      defer_q    <= defer_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_sprite_port_arbiter.sv
// Directed bench for sprite_port_arbiter: inputs change just after the falling
// edge and outputs are checked 1 ns later, well away from the rising edge.
module tb_sprite_port_arbiter;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_DEFER  = 8;

  logic clock;
  logic reset_n;
  int unsigned n_checks;
  int unsigned n_fail;

  sprite_port_arbiter_if #(
    .SEL_W(SEL_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  sprite_port_arbiter #(
    .SEL_W(SEL_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_DEFER(MAX_DEFER)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_wr(input logic v, input logic [3:0] s, input logic [11:0] a, input logic [7:0] d);
    bus.wq_valid  = v;
    bus.wq_select = s;
    bus.wq_addr   = a;
    bus.wq_data   = d;
  endtask

  task automatic set_rd(input logic r, input logic [3:0] s, input logic [11:0] a);
    bus.rd_req    = r;
    bus.rd_select = s;
    bus.rd_addr   = a;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for three edges with both requesters active.
    reset_n = 1'b0;
    set_wr(1'b1, 4'h1, 12'h001, 8'h00);
    set_rd(1'b1, 4'h1, 12'h001);
    repeat (3) @(negedge clock);
    #1;
    check("rst_wq_ready", bus.wq_ready, 0);
    check("rst_rd_grant", bus.rd_grant, 0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_level",    bus.fifo_level, 0);

    @(negedge clock);
    reset_n = 1'b1;
    set_wr(1'b0, 4'h0, 12'h000, 8'h00);
    set_rd(1'b0, 4'h0, 12'h000);
    #1;
    check("rel_wq_ready", bus.wq_ready, 1);
    check("rel_mem_we",   bus.mem_we,   0);

    // Idle write: issued the cycle after the push, never in the push cycle.
    @(negedge clock);
    set_wr(1'b1, 4'h3, 12'h010, 8'hA5);
    #1;
    check("iw_ready",     bus.wq_ready, 1);
    check("iw_no_bypass", bus.mem_we,   0);
    @(negedge clock);
    set_wr(1'b0, 4'h0, 12'h000, 8'h00);
    #1;
    check("iw_we",    bus.mem_we,     1);
    check("iw_sel",   bus.mem_select, 3);
    check("iw_addr",  bus.mem_addr,   12'h010);
    check("iw_data",  bus.mem_wdata,  8'hA5);
    check("iw_level", bus.fifo_level, 1);
    @(negedge clock);
    #1;
    check("iw_level0", bus.fifo_level, 0);
    check("iw_we0",    bus.mem_we,     0);

    // Read priority with an empty FIFO.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      set_rd(1'b1, 4'h2, 12'h100);
      #1;
      check("rp_grant",    bus.rd_grant,   1);
      check("rp_we",       bus.mem_we,     0);
      check("rp_sel",      bus.mem_select, 2);
      check("rp_addr",     bus.mem_addr,   12'h100);
      check("rp_rd_valid", bus.rd_valid,   (i == 0) ? 0 : 1);
    end
    @(negedge clock);
    set_rd(1'b0, 4'h2, 12'h100);
    #1;
    check("rp_grant_off", bus.rd_grant, 0);
    check("rp_valid_lag", bus.rd_valid, 1);
    @(negedge clock);
    #1;
    check("rp_valid_off", bus.rd_valid, 0);

    // Starvation bound: one buffered write loses exactly MAX_DEFER reads.
    @(negedge clock);
    set_wr(1'b1, 4'h5, 12'h0AB, 8'h3C);
    set_rd(1'b1, 4'h2, 12'h100);
    #1;
    check("sv_push_grant", bus.rd_grant, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) set_wr(1'b0, 4'h0, 12'h000, 8'h00);
      #1;
      check("sv_grant", bus.rd_grant,   1);
      check("sv_we",    bus.mem_we,     0);
      check("sv_level", bus.fifo_level, 1);
    end
    @(negedge clock);
    #1;
    check("sv_force_grant", bus.rd_grant,   0);
    check("sv_force_we",    bus.mem_we,     1);
    check("sv_force_sel",   bus.mem_select, 5);
    check("sv_force_addr",  bus.mem_addr,   12'h0AB);
    check("sv_force_data",  bus.mem_wdata,  8'h3C);
    @(negedge clock);
    #1;
    check("sv_resume_grant", bus.rd_grant,   1);
    check("sv_resume_level", bus.fifo_level, 0);
    check("sv_lost_valid",   bus.rd_valid,   0);

    // Full FIFO under constant reads; the fifth write is held by the source.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      set_wr(1'b1, 4'(i), 12'(12'h200 + i), 8'(8'h11 + i));
      #1;
      check("ff_ready", bus.wq_ready, 1);
      check("ff_grant", bus.rd_grant, 1);
    end
    @(negedge clock);
    set_wr(1'b1, 4'h4, 12'h204, 8'h15);
    #1;
    check("ff_full_ready", bus.wq_ready,   0);
    check("ff_full_level", bus.fifo_level, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check("ff_hold_ready", bus.wq_ready, 0);
      check("ff_hold_grant", bus.rd_grant, 1);
      check("ff_hold_we",    bus.mem_we,   0);
    end
    @(negedge clock);
    #1;
    check("ff_force_grant", bus.rd_grant,   0);
    check("ff_force_we",    bus.mem_we,     1);
    check("ff_force_sel",   bus.mem_select, 0);
    check("ff_force_addr",  bus.mem_addr,   12'h200);
    check("ff_force_data",  bus.mem_wdata,  8'h11);
    check("ff_force_ready", bus.wq_ready,   0);
    @(negedge clock);
    #1;
    check("ff_accept_ready", bus.wq_ready,   1);
    check("ff_accept_level", bus.fifo_level, 3);
    check("ff_accept_grant", bus.rd_grant,   1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 1) begin
        set_wr(1'b0, 4'h0, 12'h000, 8'h00);
        set_rd(1'b0, 4'h0, 12'h000);
      end
      #1;
      check("ff_drain_level", bus.fifo_level, 5 - i);
      check("ff_drain_we",    bus.mem_we,     1);
      check("ff_drain_sel",   bus.mem_select, i);
      check("ff_drain_addr",  bus.mem_addr,   12'h200 + i);
      check("ff_drain_data",  bus.mem_wdata,  8'h11 + i);
    end
    @(negedge clock);
    #1;
    check("ff_empty_level", bus.fifo_level, 0);
    check("ff_empty_we",    bus.mem_we,     0);

    // Mid-operation reset discards buffered writes.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      set_wr(1'b1, 4'h7, 12'(12'h300 + i), 8'(8'h40 + i));
      set_rd(1'b1, 4'h2, 12'h100);
      #1;
      check("mr_ready", bus.wq_ready, 1);
    end
    @(negedge clock);
    set_wr(1'b0, 4'h0, 12'h000, 8'h00);
    reset_n = 1'b0;
    #1;
    check("mr_level_pre", bus.fifo_level, 3);
    check("mr_rst_ready", bus.wq_ready,   0);
    check("mr_rst_grant", bus.rd_grant,   0);
    check("mr_rst_we",    bus.mem_we,     0);
    @(negedge clock);
    reset_n = 1'b1;
    set_rd(1'b0, 4'h0, 12'h000);
    #1;
    check("mr_level",    bus.fifo_level, 0);
    check("mr_rd_valid", bus.rd_valid,   0);
    check("mr_ready",    bus.wq_ready,   1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check("mr_no_we",    bus.mem_we,     0);
      check("mr_level_hd", bus.fifo_level, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_port_arbiter.md
Name: sprite_port_arbiter

Overview:
- Shares the single read/write port (port A) of sprite storage between two requesters: the SPI sprite-upload path (writes) and the renderer's primary sprite fetch (reads).
- Upload writes are buffered in a small FIFO.
- Renderer reads have priority.
- A deferral counter bounds write starvation by stalling the renderer for one slot.
- Sits between the SPI write controller / renderer and the sprite storage port A.

Parameters:
SEL_W, 4, width of sprite select (log2 of sprite count)
ADDR_W, 12, width of 4-bit-granular sprite address
FIFO_DEPTH, 4, write buffer entries (power of two, >=2)
MAX_DEFER, 8, consecutive read slots a pending write may lose before it is forced

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
wq_valid  in  1  upload write request valid
wq_ready  out  1  FIFO can accept a write this cycle
wq_select  in  SEL_W  sprite index of write
wq_addr  in  ADDR_W  address within sprite of write
wq_data  in  8  write byte
rd_req  in  1  renderer read request
rd_select  in  SEL_W  sprite index of read
rd_addr  in  ADDR_W  address within sprite of read
rd_grant  out  1  read accepted this cycle (combinational)
rd_valid  out  1  storage output holds granted read data
mem_we  out  1  port A write enable
mem_select  out  SEL_W  port A sprite index
mem_addr  out  ADDR_W  port A address
mem_wdata  out  8  port A write data
fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered write count

Behaviour:
- Synchronous active-low reset: reset_n sampled only on the rising edge of clock.
- Reset values: FIFO empty, fifo_level=0, defer_cnt=0, rd_valid=0, mem_we=0.
- While reset_n=0: wq_ready=0, rd_grant=0.
- Reset mid-operation discards buffered writes and any pending rd_valid.
- Write accept:
  - wq_ready = (fifo_level < FIFO_DEPTH).
  - Push on wq_valid && wq_ready, capturing {select, addr, data}.
  - There is no same-cycle bypass: a pushed entry is issuable the following cycle at the earliest.
- Slot arbitration is combinational, one decision per cycle, with force = (fifo_level!=0) && (defer_cnt==MAX_DEFER):
  - FORCE_WRITE (force): pop FIFO head; mem_we=1; mem_* = head fields; rd_grant=0.
  - READ (!force && rd_req): rd_grant=1; mem_we=0; mem_select/mem_addr = rd_select/rd_addr.
  - WRITE (!force && !rd_req && fifo_level!=0): pop head; mem_we=1; mem_* = head.
  - IDLE: mem_we=0; mem_select/mem_addr = rd_select/rd_addr; mem_wdata = head data (don't-care).
- defer_cnt:
  - Cleared to 0 on any write slot (FORCE_WRITE or WRITE), and whenever the FIFO is empty.
  - In a READ slot with fifo_level!=0: increments, saturating at MAX_DEFER.
- Read latency: rd_valid is registered, rd_valid <= rd_grant. Data appears on storage douta in the cycle rd_valid=1. The arbiter does not register data.
- Simultaneous push and pop: fifo_level unchanged. A push when full is refused via wq_ready=0; the source holds.
- Pointers wrap modulo FIFO_DEPTH.
- The renderer holds rd_req and its address until rd_grant=1. A forced slot costs the renderer exactly one cycle.

Test Plan:
- Reset hold: reset_n=0 for 3 cycles with wq_valid=1, rd_req=1 -> wq_ready=0, rd_grant=0, mem_we=0, rd_valid=0, fifo_level=0. After release, wq_ready=1.
- Idle write: push {sel=3, addr=0x010, data=0xA5} with rd_req=0 -> next cycle mem_we=1, mem_select=3, mem_addr=0x010, mem_wdata=0xA5. fifo_level returns to 0.
- Read priority: rd_req=1 every cycle, sel=2 addr=0x100 -> rd_grant=1 each cycle, rd_valid follows 1 cycle later. With no FIFO entries, mem_we stays 0.
- Starvation bound (MAX_DEFER=8): 1 write buffered, rd_req held high -> 8 grants, then 1 cycle with rd_grant=0 and mem_we=1, then grants resume. defer_cnt=0 after the forced slot.
- Full FIFO: 5 pushes attempted back-to-back while rd_req=1 (DEPTH=4) -> wq_ready=0 on the 5th, fifo_level=4. After the next forced write, wq_ready=1 and the held 5th write is accepted. The order written to mem is preserved.
- Mid-op reset: 3 writes buffered, reset_n=0 for 1 cycle -> fifo_level=0, no further mem_we=1 without new pushes.
